// File: rtl/reorder_buffer.sv
// reorder_buffer: 16-entry circular ROB, dual dispatch, three completion ports,
// dual in-order retire with old physical mapping returned to the free pool.
module reorder_buffer #(
   parameter int DEPTH  = 16,
   parameter int PREG_W = 6,
   localparam int IDX_W = $clog2(DEPTH),
   localparam int CNT_W = IDX_W + 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   input  logic              alloc_valid_1,
   input  logic              alloc_valid_2,
   input  logic [4:0]        alloc_rd_1,
   input  logic [4:0]        alloc_rd_2,
   input  logic [PREG_W-1:0] alloc_pd_1,
   input  logic [PREG_W-1:0] alloc_pd_2,
   input  logic [PREG_W-1:0] alloc_old_pd_1,
   input  logic [PREG_W-1:0] alloc_old_pd_2,
   output logic              alloc_ready,
   output logic [IDX_W-1:0]  alloc_idx_1,
   output logic [IDX_W-1:0]  alloc_idx_2,
   input  logic              cmpl_valid_0,
   input  logic              cmpl_valid_1,
   input  logic              cmpl_valid_2,
   input  logic [IDX_W-1:0]  cmpl_idx_0,
   input  logic [IDX_W-1:0]  cmpl_idx_1,
   input  logic [IDX_W-1:0]  cmpl_idx_2,
   output logic              retire_valid_1,
   output logic              retire_valid_2,
   output logic [4:0]        retire_rd_1,
   output logic [4:0]        retire_rd_2,
   output logic [PREG_W-1:0] retire_pd_1,
   output logic [PREG_W-1:0] retire_pd_2,
   output logic              free_valid_1,
   output logic              free_valid_2,
   output logic [PREG_W-1:0] free_pd_1,
   output logic [PREG_W-1:0] free_pd_2,
   output logic [CNT_W-1:0]  count,
   output logic              empty,
   output logic              full
);

   localparam logic [CNT_W-1:0] READY_MAX = CNT_W'(DEPTH - 2);
   localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH);

   logic [DEPTH-1:0]  valid_q, valid_d;
   logic [DEPTH-1:0]  done_q, done_d;
   logic [4:0]        rd_q  [DEPTH];
   logic [PREG_W-1:0] pd_q  [DEPTH];
   logic [PREG_W-1:0] old_q [DEPTH];

   logic [IDX_W-1:0]  head_q, head_d, tail_q, tail_d;
   logic [IDX_W-1:0]  head_p1, tail_p1;
   logic [CNT_W-1:0]  count_q, count_d;

   logic              acc1, acc2, ret1, ret2;

   logic              rv1_q, rv2_q, fv1_q, fv2_q;
   logic [4:0]        rrd1_q, rrd2_q;
   logic [PREG_W-1:0] rpd1_q, rpd2_q, fpd1_q, fpd2_q;

   assign head_p1 = head_q + IDX_W'(1);
   assign tail_p1 = tail_q + IDX_W'(1);

   // Acceptance looks only at the current count; same-cycle retires are not credited.
   assign alloc_ready = (count_q <= READY_MAX);
   assign acc1        = alloc_valid_1 & alloc_ready;
   assign acc2        = acc1 & alloc_valid_2;

   // Slot 2 can only retire behind slot 1, which keeps retirement in order.
   assign ret1 = valid_q[head_q] & done_q[head_q];
   assign ret2 = ret1 & valid_q[head_p1] & done_q[head_p1];

   assign alloc_idx_1 = tail_q;
   assign alloc_idx_2 = tail_p1;
   assign count       = count_q;
   assign empty       = (count_q == '0);
   assign full        = (count_q == FULL_CNT);

   assign retire_valid_1 = rv1_q;
   assign retire_valid_2 = rv2_q;
   assign retire_rd_1    = rrd1_q;
   assign retire_rd_2    = rrd2_q;
   assign retire_pd_1    = rpd1_q;
   assign retire_pd_2    = rpd2_q;
   assign free_valid_1   = fv1_q;
   assign free_valid_2   = fv2_q;
   assign free_pd_1      = fpd1_q;
   assign free_pd_2      = fpd2_q;

   // Next valid/done bits: completion set, retire clear, allocation write, flush wipes all.
   // Allocated slots are never live and never the head pair while count <= DEPTH-2,
   // so the three updates never target the same entry.
   always_comb begin
      valid_d = valid_q;
      done_d  = done_q;
      for (int i = 0; i < DEPTH; i++) begin
         if (valid_q[i] &&
             ((cmpl_valid_0 && cmpl_idx_0 == IDX_W'(i)) ||
              (cmpl_valid_1 && cmpl_idx_1 == IDX_W'(i)) ||
              (cmpl_valid_2 && cmpl_idx_2 == IDX_W'(i))))
            done_d[i] = 1'b1;
      end
      if (ret1) begin
         valid_d[head_q] = 1'b0;
         done_d[head_q]  = 1'b0;
      end
      if (ret2) begin
         valid_d[head_p1] = 1'b0;
         done_d[head_p1]  = 1'b0;
      end
      if (acc1) begin
         valid_d[tail_q] = 1'b1;
         done_d[tail_q]  = 1'b0;
      end
      if (acc2) begin
         valid_d[tail_p1] = 1'b1;
         done_d[tail_p1]  = 1'b0;
      end
      if (flush) begin
         valid_d = '0;
         done_d  = '0;
      end
   end

   // Pointer and occupancy next-state.
   always_comb begin
      head_d  = head_q + IDX_W'(ret1) + IDX_W'(ret2);
      tail_d  = tail_q + IDX_W'(acc1) + IDX_W'(acc2);
      count_d = count_q + CNT_W'(acc1) + CNT_W'(acc2) - CNT_W'(ret1) - CNT_W'(ret2);
      if (flush) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end
   end

   // Entry status bits and pointers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= '0;
         done_q  <= '0;
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         valid_q <= valid_d;
         done_q  <= done_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   // Entry payload, written on acceptance only.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            rd_q[i]  <= '0;
            pd_q[i]  <= '0;
            old_q[i] <= '0;
         end
      end else if (!flush) begin
         if (acc1) begin
            rd_q[tail_q]  <= alloc_rd_1;
            pd_q[tail_q]  <= alloc_pd_1;
            old_q[tail_q] <= alloc_old_pd_1;
         end
         if (acc2) begin
            rd_q[tail_p1]  <= alloc_rd_2;
            pd_q[tail_p1]  <= alloc_pd_2;
            old_q[tail_p1] <= alloc_old_pd_2;
         end
      end
   end

   // Registered retire/free strobes; rd = 0 never frees its old mapping.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n || 1'b0) begin
         rv1_q  <= 1'b0;
         rv2_q  <= 1'b0;
         fv1_q  <= 1'b0;
         fv2_q  <= 1'b0;
         rrd1_q <= '0;
         rrd2_q <= '0;
         rpd1_q <= '0;
         rpd2_q <= '0;
         fpd1_q <= '0;
         fpd2_q <= '0;
      end else if (flush) begin
         rv1_q <= 1'b0;
         rv2_q <= 1'b0;
         fv1_q <= 1'b0;
         fv2_q <= 1'b0;
      end else begin
         rv1_q  <= ret1;
         rv2_q  <= ret2;
         fv1_q  <= ret1 & (rd_q[head_q] != 5'd0);
         fv2_q  <= ret2 & (rd_q[head_p1] != 5'd0);
         rrd1_q <= ret1 ? rd_q[head_q]   : 5'd0;
         rrd2_q <= ret2 ? rd_q[head_p1]  : 5'd0;
         rpd1_q <= ret1 ? pd_q[head_q]   : '0;
         rpd2_q <= ret2 ? pd_q[head_p1]  : '0;
         fpd1_q <= ret1 ? old_q[head_q]  : '0;
         fpd2_q <= ret2 ? old_q[head_p1] : '0;
      end
   end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed self-checking bench for reorder_buffer.
module tb_reorder_buffer;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       flush;
   logic       alloc_valid_1, alloc_valid_2;
   logic [4:0] alloc_rd_1, alloc_rd_2;
   logic [5:0] alloc_pd_1, alloc_pd_2, alloc_old_pd_1, alloc_old_pd_2;
   logic       alloc_ready;
   logic [3:0] alloc_idx_1, alloc_idx_2;
   logic       cmpl_valid_0, cmpl_valid_1, cmpl_valid_2;
   logic [3:0] cmpl_idx_0, cmpl_idx_1, cmpl_idx_2;
   logic       retire_valid_1, retire_valid_2;
   logic [4:0] retire_rd_1, retire_rd_2;
   logic [5:0] retire_pd_1, retire_pd_2;
   logic       free_valid_1, free_valid_2;
   logic [5:0] free_pd_1, free_pd_2;
   logic [4:0] count;
   logic       empty, full;

   int checks = 0;
   int errors = 0;

   reorder_buffer dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .alloc_valid_1(alloc_valid_1), .alloc_valid_2(alloc_valid_2),
      .alloc_rd_1(alloc_rd_1), .alloc_rd_2(alloc_rd_2),
      .alloc_pd_1(alloc_pd_1), .alloc_pd_2(alloc_pd_2),
      .alloc_old_pd_1(alloc_old_pd_1), .alloc_old_pd_2(alloc_old_pd_2),
      .alloc_ready(alloc_ready), .alloc_idx_1(alloc_idx_1), .alloc_idx_2(alloc_idx_2),
      .cmpl_valid_0(cmpl_valid_0), .cmpl_valid_1(cmpl_valid_1), .cmpl_valid_2(cmpl_valid_2),
      .cmpl_idx_0(cmpl_idx_0), .cmpl_idx_1(cmpl_idx_1), .cmpl_idx_2(cmpl_idx_2),
      .retire_valid_1(retire_valid_1), .retire_valid_2(retire_valid_2),
      .retire_rd_1(retire_rd_1), .retire_rd_2(retire_rd_2),
      .retire_pd_1(retire_pd_1), .retire_pd_2(retire_pd_2),
      .free_valid_1(free_valid_1), .free_valid_2(free_valid_2),
      .free_pd_1(free_pd_1), .free_pd_2(free_pd_2),
      .count(count), .empty(empty), .full(full)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_alloc(input logic v1, input int rd1, input int pd1, input int old1,
                            input logic v2, input int rd2, input int pd2, input int old2);
      alloc_valid_1  = v1;
      alloc_rd_1     = 5'(rd1);
      alloc_pd_1     = 6'(pd1);
      alloc_old_pd_1 = 6'(old1);
      alloc_valid_2  = v2;
      alloc_rd_2     = 5'(rd2);
      alloc_pd_2     = 6'(pd2);
      alloc_old_pd_2 = 6'(old2);
   endtask

   task automatic set_cmpl(input logic v0, input int i0, input logic v1, input int i1,
                           input logic v2, input int i2);
      cmpl_valid_0 = v0;
      cmpl_idx_0   = 4'(i0);
      cmpl_valid_1 = v1;
      cmpl_idx_1   = 4'(i1);
      cmpl_valid_2 = v2;
      cmpl_idx_2   = 4'(i2);
   endtask

   task automatic test_reset();
      flush = 1'b0;
      set_alloc(0, 0, 0, 0, 0, 0, 0, 0);
      set_cmpl(0, 0, 0, 0, 0, 0);
      rst_n = 1'b0;
      #12 rst_n = 1'b1;
      step();
      step();
      checks++; if (alloc_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got %b exp 1", alloc_ready); end
      checks++; if (empty !== 1'b1) begin errors++; $display("FAIL rst_empty got %b exp 1", empty); end
      checks++; if (full !== 1'b0) begin errors++; $display("FAIL rst_full got %b exp 0", full); end
      checks++; if (count !== 5'd0) begin errors++; $display("FAIL rst_count got %0d exp 0", count); end
      checks++; if (alloc_idx_1 !== 4'd0 || alloc_idx_2 !== 4'd1) begin errors++; $display("FAIL rst_idx got %0d/%0d exp 0/1", alloc_idx_1, alloc_idx_2); end
      checks++; if (retire_valid_1 !== 1'b0 || retire_valid_2 !== 1'b0 || free_valid_1 !== 1'b0 || free_valid_2 !== 1'b0) begin errors++; $display("FAIL rst_strobes got %b%b%b%b exp 0000", retire_valid_1, retire_valid_2, free_valid_1, free_valid_2); end
   endtask

   task automatic test_dual_inorder();
      set_alloc(1, 3, 33, 3, 1, 4, 34, 4);
      step();
      set_alloc(0, 0, 0, 0, 0, 0, 0, 0);
      checks++; if (count !== 5'd2) begin errors++; $display("FAIL dual_count got %0d exp 2", count); end
      checks++; if (alloc_idx_1 !== 4'd2) begin errors++; $display("FAIL dual_tail got %0d exp 2", alloc_idx_1); end
      set_cmpl(1, 0, 1, 1, 0, 0);
      step();
      set_cmpl(0, 0, 0, 0, 0, 0);
      checks++; if (retire_valid_1 !== 1'b0) begin errors++; $display("FAIL dual_early got %b exp 0", retire_valid_1); end
      step();
      checks++; if (retire_valid_1 !== 1'b1 || retire_valid_2 !== 1'b1) begin errors++; $display("FAIL dual_rv got %b%b exp 11", retire_valid_1, retire_valid_2); end
      checks++; if (retire_pd_1 !== 6'd33 || retire_pd_2 !== 6'd34) begin errors++; $display("FAIL dual_rpd got %0d/%0d exp 33/34", retire_pd_1, retire_pd_2); end
      checks++; if (retire_rd_1 !== 5'd3 || retire_rd_2 !== 5'd4) begin errors++; $display("FAIL dual_rrd got %0d/%0d exp 3/4", retire_rd_1, retire_rd_2); end
      checks++; if (free_valid_1 !== 1'b1 || free_valid_2 !== 1'b1) begin errors++; $display("FAIL dual_fv got %b%b exp 11", free_valid_1, free_valid_2); end
      checks++; if (free_pd_1 !== 6'd3 || free_pd_2 !== 6'd4) begin errors++; $display("FAIL dual_fpd got %0d/%0d exp 3/4", free_pd_1, free_pd_2); end
      checks++; if (count !== 5'd0 || empty !== 1'b1) begin errors++; $display("FAIL dual_drain got %0d/%b exp 0/1", count, empty); end
      step();
      checks++; if (retire_valid_1 !== 1'b0 || free_valid_1 !== 1'b0) begin errors++; $display("FAIL dual_pulse got %b/%b exp 0/0", retire_valid_1, free_valid_1); end
   endtask

   task automatic test_out_of_order();
      checks++; if (alloc_idx_1 !== 4'd2) begin errors++; $display("FAIL ooo_tag got %0d exp 2", alloc_idx_1); end
      set_alloc(1, 5, 40, 5, 1, 6, 41, 6);
      step();
      set_alloc(0, 0, 0, 0, 0, 0, 0, 0);
      set_cmpl(0, 0, 0, 0, 1, 3);
      step();
      set_cmpl(0, 0, 0, 0, 0, 0);
      step();
      checks++; if (retire_valid_1 !== 1'b0 || count !== 5'd2) begin errors++; $display("FAIL ooo_hold1 got %b/%0d exp 0/2", retire_valid_1, count); end
      step();
      checks++; if (retire_valid_1 !== 1'b0 || count !== 5'd2) begin errors++; $display("FAIL ooo_hold2 got %b/%0d exp 0/2", retire_valid_1, count); end
      set_cmpl(1, 2, 0, 0, 0, 0);
      step();
      set_cmpl(0, 0, 0, 0, 0, 0);
      step();
      checks++; if (retire_valid_1 !== 1'b1 || retire_valid_2 !== 1'b1) begin errors++; $display("FAIL ooo_rv got %b%b exp 11", retire_valid_1, retire_valid_2); end
      checks++; if (retire_pd_1 !== 6'd40 || retire_pd_2 !== 6'd41) begin errors++; $display("FAIL ooo_order got %0d/%0d exp 40/41", retire_pd_1, retire_pd_2); end
      checks++; if (free_pd_1 !== 6'd5 || free_pd_2 !== 6'd6) begin errors++; $display("FAIL ooo_fpd got %0d/%0d exp 5/6", free_pd_1, free_pd_2); end
   endtask

   task automatic test_x0_and_ignore();
      // slot 2 alone is ignored
      set_alloc(0, 0, 0, 0, 1, 9, 9, 9);
      step();
      checks++; if (count !== 5'd0 || alloc_idx_1 !== 4'd4) begin errors++; $display("FAIL slot2_only got %0d/%0d exp 0/4", count, alloc_idx_1); end
      set_alloc(1, 0, 0, 0, 0, 0, 0, 0);
      step();
      set_alloc(0, 0, 0, 0, 0, 0, 0, 0);
      set_cmpl(1, 4, 1, 4, 0, 0);
      step();
      set_cmpl(0, 0, 0, 0, 0, 0);
      step();
      checks++; if (retire_valid_1 !== 1'b1 || free_valid_1 !== 1'b0 || retire_valid_2 !== 1'b0) begin errors++; $display("FAIL x0_strobes got %b%b%b exp 100", retire_valid_1, free_valid_1, retire_valid_2); end
      // completion to an invalid entry must not stick
      set_cmpl(0, 0, 0, 0, 1, 5);
      step();
      set_cmpl(0, 0, 0, 0, 0, 0);
      set_alloc(1, 7, 50, 7, 0, 0, 0, 0);
      step();
      set_alloc(0, 0, 0, 0, 0, 0, 0, 0);
      step();
      step();
      checks++; if (retire_valid_1 !== 1'b0 || count !== 5'd1) begin errors++; $display("FAIL stale_cmpl got %b/%0d exp 0/1", retire_valid_1, count); end
      set_cmpl(0, 0, 0, 0, 1, 5);
      step();
      set_cmpl(0, 0, 0, 0, 0, 0);
      step();
      checks++; if (retire_pd_1 !== 6'd50 || free_pd_1 !== 6'd7 || free_valid_1 !== 1'b1) begin errors++; $display("FAIL late_ret got %0d/%0d/%b exp 50/7/1", retire_pd_1, free_pd_1, free_valid_1); end
   endtask

   task automatic test_fill_wrap();
      // head = tail = 6; entry k gets rd k+1, pd k+32, old k+1, tag (6+k)%16
      for (int p = 0; p < 8; p++) begin
         checks++; if (alloc_ready !== 1'b1) begin errors++; $display("FAIL fill_ready%0d got %b exp 1", p, alloc_ready); end
         set_alloc(1, 2*p+1, 2*p+32, 2*p+1, 1, 2*p+2, 2*p+33, 2*p+2);
         step();
      end
      checks++; if (count !== 5'd16 || full !== 1'b1 || alloc_ready !== 1'b0) begin errors++; $display("FAIL fill_full got %0d/%b/%b exp 16/1/0", count, full, alloc_ready); end
      checks++; if (alloc_idx_1 !== 4'd6 || alloc_idx_2 !== 4'd7) begin errors++; $display("FAIL fill_tail got %0d/%0d exp 6/7", alloc_idx_1, alloc_idx_2); end
      set_cmpl(1, 6, 0, 0, 0, 0);
      step();
      set_cmpl(0, 0, 0, 0, 0, 0);
      checks++; if (count !== 5'd16) begin errors++; $display("FAIL full_drop got %0d exp 16", count); end
      step();
      checks++; if (retire_pd_1 !== 6'd32 || free_pd_1 !== 6'd1 || count !== 5'd15) begin errors++; $display("FAIL ret_at_full got %0d/%0d/%0d exp 32/1/15", retire_pd_1, free_pd_1, count); end
      checks++; if (alloc_ready !== 1'b0 || full !== 1'b0) begin errors++; $display("FAIL cnt15_ready got %b/%b exp 0/0", alloc_ready, full); end
      step();
      checks++; if (count !== 5'd15 || retire_valid_1 !== 1'b0) begin errors++; $display("FAIL cnt15_drop got %0d/%b exp 15/0", count, retire_valid_1); end
      set_alloc(0, 0, 0, 0, 0, 0, 0, 0);
      set_cmpl(1, 7, 1, 8, 1, 9);
      step();
      set_cmpl(1, 10, 1, 11, 1, 12);
      step();
      set_cmpl(1, 13, 0, 0, 0, 0);
      step();
      set_cmpl(0, 0, 0, 0, 0, 0);
      step();
      step();
      step();
      checks++; if (count !== 5'd8) begin errors++; $display("FAIL drain7 got %0d exp 8", count); end
      // head = 14, tail = 6: refill to 14 with k = 16..21
      for (int p = 0; p < 3; p++) begin
         set_alloc(1, 17+2*p, 48+2*p, 17+2*p, 1, 18+2*p, 49+2*p, 18+2*p);
         step();
      end
      set_alloc(0, 0, 0, 0, 0, 0, 0, 0);
      checks++; if (count !== 5'd14 || alloc_ready !== 1'b1) begin errors++; $display("FAIL cnt14 got %0d/%b exp 14/1", count, alloc_ready); end
      set_cmpl(1, 14, 1, 15, 0, 0);
      step();
      set_cmpl(0, 0, 0, 0, 0, 0);
      set_alloc(1, 23, 54, 23, 1, 24, 55, 24);
      step();
      set_alloc(0, 0, 0, 0, 0, 0, 0, 0);
      checks++; if (count !== 5'd14) begin errors++; $display("FAIL b2b_count got %0d exp 14", count); end
      checks++; if (retire_pd_1 !== 6'd40 || retire_pd_2 !== 6'd41) begin errors++; $display("FAIL b2b_rpd got %0d/%0d exp 40/41", retire_pd_1, retire_pd_2); end
      checks++; if (free_pd_1 !== 6'd9 || free_pd_2 !== 6'd10) begin errors++; $display("FAIL b2b_fpd got %0d/%0d exp 9/10", free_pd_1, free_pd_2); end
      checks++; if (alloc_idx_1 !== 4'd14 || alloc_idx_2 !== 4'd15) begin errors++; $display("FAIL b2b_tail got %0d/%0d exp 14/15", alloc_idx_1, alloc_idx_2); end
      set_cmpl(1, 0, 1, 1, 0, 0);
      step();
      set_cmpl(0, 0, 0, 0, 0, 0);
      step();
      checks++; if (retire_pd_1 !== 6'd42 || retire_pd_2 !== 6'd43 || count !== 5'd12) begin errors++; $display("FAIL head_wrap got %0d/%0d/%0d exp 42/43/12", retire_pd_1, retire_pd_2, count); end
   endtask

   task automatic test_flush();
      flush = 1'b1;
      step();
      flush = 1'b0;
      checks++; if (count !== 5'd0 || alloc_idx_1 !== 4'd0) begin errors++; $display("FAIL flush1 got %0d/%0d exp 0/0", count, alloc_idx_1); end
      set_alloc(1, 1, 20, 21, 1, 2, 22, 23);
      step();
      step();
      set_alloc(1, 1, 20, 21, 0, 0, 0, 0);
      step();
      set_alloc(0, 0, 0, 0, 0, 0, 0, 0);
      checks++; if (count !== 5'd5) begin errors++; $display("FAIL live5 got %0d exp 5", count); end
      set_cmpl(1, 0, 1, 1, 0, 0);
      step();
      set_cmpl(0, 0, 0, 0, 0, 0);
      flush = 1'b1;
      set_alloc(1, 3, 30, 31, 0, 0, 0, 0);
      step();
      flush = 1'b0;
      set_alloc(0, 0, 0, 0, 0, 0, 0, 0);
      checks++; if (count !== 5'd0 || empty !== 1'b1 || alloc_idx_1 !== 4'd0) begin errors++; $display("FAIL flush_state got %0d/%b/%0d exp 0/1/0", count, empty, alloc_idx_1); end
      checks++; if (retire_valid_1 !== 1'b0 || free_valid_1 !== 1'b0 || free_valid_2 !== 1'b0) begin errors++; $display("FAIL flush_strobes got %b%b%b exp 000", retire_valid_1, free_valid_1, free_valid_2); end
      step();
      checks++; if (retire_valid_1 !== 1'b0 || count !== 5'd0) begin errors++; $display("FAIL flush_after got %b/%0d exp 0/0", retire_valid_1, count); end
   endtask

   task automatic test_async_reset();
      set_alloc(1, 9, 50, 51, 1, 10, 52, 53);
      step();
      set_cmpl(1, 0, 1, 1, 0, 0);
      step();
      set_cmpl(0, 0, 0, 0, 0, 0);
      step();
      checks++; if (retire_valid_1 !== 1'b1 || retire_pd_1 !== 6'd50 || count !== 5'd4) begin errors++; $display("FAIL burst got %b/%0d/%0d exp 1/50/4", retire_valid_1, retire_pd_1, count); end
      #2 rst_n = 1'b0;
      #1;
      checks++; if (count !== 5'd0 || empty !== 1'b1 || full !== 1'b0 || alloc_ready !== 1'b1) begin errors++; $display("FAIL arst_state got %0d/%b/%b/%b exp 0/1/0/1", count, empty, full, alloc_ready); end
      checks++; if (alloc_idx_1 !== 4'd0 || alloc_idx_2 !== 4'd1) begin errors++; $display("FAIL arst_idx got %0d/%0d exp 0/1", alloc_idx_1, alloc_idx_2); end
      checks++; if (retire_valid_1 !== 1'b0 || retire_valid_2 !== 1'b0 || free_valid_1 !== 1'b0 || free_valid_2 !== 1'b0 || retire_pd_1 !== 6'd0 || free_pd_1 !== 6'd0) begin errors++; $display("FAIL arst_ret got %b%b%b%b pd %0d fpd %0d exp 0000 0 0", retire_valid_1, retire_valid_2, free_valid_1, free_valid_2, retire_pd_1, free_pd_1); end
      set_alloc(0, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      rst_n = 1'b1;
      step();
      checks++; if (count !== 5'd0 || retire_valid_1 !== 1'b0) begin errors++; $display("FAIL arst_release got %0d/%b exp 0/0", count, retire_valid_1); end
   endtask

   initial begin
      test_reset();
      test_dual_inorder();
      test_out_of_order();
      test_x0_and_ignore();
      test_fill_wrap();
      test_flush();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
